// File: rtl/cal_date_if.sv
// Date-chain bus between the time-of-day chain, the buttons and the date block.
// The master drives the tick and the buttons; the slave owns the date outputs.
`timescale 1ns/1ps
interface cal_date_if;
  logic       day_tick;
  logic       set_btn;
  logic       adv_btn;
  logic [6:0] day_o;
  logic [6:0] mon_o;
  logic [6:0] yr_o;
  logic [1:0] mode_o;
  logic       eom_o;
  logic       yr_wrap_o;

  modport master (
    output day_tick, set_btn, adv_btn,
    input  day_o, mon_o, yr_o, mode_o, eom_o, yr_wrap_o
  );

  modport slave (
    input  day_tick, set_btn, adv_btn,
    output day_o, mon_o, yr_o, mode_o, eom_o, yr_wrap_o
  );
endinterface

// File: rtl/cal_date_ctrl.sv
// Day/month/year counters with month lengths, 4-year leap rule
// and a button-driven set sequence (year, month, day).
`timescale 1ns/1ps
module cal_date_ctrl #(
  parameter int YR_MAX = 99
) (
  input logic      clk,
  input logic      rst,
  cal_date_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_YR  = 2'd1,
    SET_MON = 2'd2,
    SET_DAY = 2'd3
  } state_t;

  localparam logic [6:0] YMAX = 7'(YR_MAX);

  state_t     state, state_n;
  logic [6:0] day, mon, yr;
  logic [6:0] day_n, mon_n, yr_n;
  logic       wrap, wrap_n;
  logic       set_q, adv_q;
  logic       set_e, adv_e, adv_go;

  function automatic logic [6:0] last_day(
    input logic [6:0] m,
    input logic [1:0] y
  );
    logic [6:0] l;
    case (m)
      7'd1:                    l = (y == 2'd0) ? 7'd28 : 7'd27;
      7'd3, 7'd5, 7'd8, 7'd10: l = 7'd29;
      default:                 l = 7'd30;
    endcase
    return l;
  endfunction

  function automatic logic [6:0] clamp(
    input logic [6:0] d,
    input logic [6:0] l
  );
    return (d > l) ? l : d;
  endfunction

  assign set_e  = bus.set_btn & ~set_q;
  assign adv_e  = bus.adv_btn & ~adv_q;
  assign adv_go = adv_e & ~set_e;

  always_comb begin
    state_n = state;
    day_n   = day;
    mon_n   = mon;
    yr_n    = yr;
    wrap_n  = 1'b0;
    if (set_e) begin
      unique case (state)
        RUN:     state_n = SET_YR;
        SET_YR:  state_n = SET_MON;
        SET_MON: state_n = SET_DAY;
        SET_DAY: state_n = RUN;
        default: state_n = RUN;
      endcase
    end
    unique case (state)
      RUN: begin
        if (bus.day_tick) begin
          if (day < last_day(mon, yr[1:0])) begin
            day_n = day + 7'd1;
          end else begin
            day_n = 7'd0;
            if (mon == 7'd11) begin
              mon_n = 7'd0;
              if (yr == YMAX) begin
                yr_n   = 7'd0;
                wrap_n = 1'b1;
              end else begin
                yr_n = yr + 7'd1;
              end
            end else begin
              mon_n = mon + 7'd1;
            end
          end
        end
      end
      SET_YR: begin
        if (adv_go) begin
          yr_n  = (yr == YMAX) ? 7'd0 : yr + 7'd1;
          day_n = clamp(day, last_day(mon, yr_n[1:0]));
        end
      end
      SET_MON: begin
        if (adv_go) begin
          mon_n = (mon == 7'd11) ? 7'd0 : mon + 7'd1;
          day_n = clamp(day, last_day(mon_n, yr[1:0]));
        end
      end
      SET_DAY: begin
        if (adv_go) begin
          day_n = (day >= last_day(mon, yr[1:0])) ? 7'd0 : day + 7'd1;
        end
      end
      default: ;
    endcase
  end

  // Button copies reset high so a button held across reset gives no edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      day   <= 7'd0;
      mon   <= 7'd0;
      yr    <= 7'd0;
      wrap  <= 1'b0;
      set_q <= 1'b1;
      adv_q <= 1'b1;
    end else begin
      state <= state_n;
      day   <= day_n;
      mon   <= mon_n;
      yr    <= yr_n;
      wrap  <= wrap_n;
      set_q <= bus.set_btn;
      adv_q <= bus.adv_btn;
    end
  end

  assign bus.day_o     = day;
  assign bus.mon_o     = mon;
  assign bus.yr_o      = yr;
  assign bus.mode_o    = state;
  assign bus.yr_wrap_o = wrap;
  assign bus.eom_o     = (day == last_day(mon, yr[1:0]));

endmodule

// File: tb/tb_cal_date_ctrl.sv
// Directed bench for cal_date_ctrl: calendar model checked every cycle
// plus literal expectations at the interesting points.
`timescale 1ns/1ps
module tb_cal_date_ctrl;

  localparam int YR_MAX = 99;

  logic clk = 1'b0;
  logic rst = 1'b1;
  cal_date_if bus ();

  cal_date_ctrl #(.YR_MAX(YR_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Calendar model: day/month/year plus mode and previous button levels
  int md, mm, my, mmode;
  int sp, ap, mwrap;

  function automatic int dim(input int m, input int y);
    int len [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m == 1 && (y % 4) == 0) return 29;
    return len[m];
  endfunction

  task automatic fix_day();
    if (md > dim(mm, my) - 1) md = dim(mm, my) - 1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      md = 0; mm = 0; my = 0; mmode = 0;
      sp = 1; ap = 1; mwrap = 0;
    end else begin
      int se, ae;
      se = (bus.set_btn && !sp) ? 1 : 0;
      ae = (bus.adv_btn && !ap) ? 1 : 0;
      mwrap = 0;
      case (mmode)
        0: if (bus.day_tick) begin
          md = md + 1;
          if (md == dim(mm, my)) begin
            md = 0;
            mm = mm + 1;
            if (mm == 12) begin
              mm = 0;
              my = my + 1;
              if (my > YR_MAX) begin
                my = 0;
                mwrap = 1;
              end
            end
          end
        end
        1: if (ae && !se) begin
          my = (my + 1) % (YR_MAX + 1);
          fix_day();
        end
        2: if (ae && !se) begin
          mm = (mm + 1) % 12;
          fix_day();
        end
        default: if (ae && !se) md = (md + 1) % dim(mm, my);
      endcase
      if (se) mmode = (mmode + 1) % 4;
      sp = bus.set_btn ? 1 : 0;
      ap = bus.adv_btn ? 1 : 0;
    end
  end

  always @(negedge clk) begin
    int eom;
    eom = (md == dim(mm, my) - 1) ? 1 : 0;
    vectors++;
    if (int'(bus.day_o) != md || int'(bus.mon_o) != mm ||
        int'(bus.yr_o) != my || int'(bus.mode_o) != mmode ||
        int'(bus.eom_o) != eom || int'(bus.yr_wrap_o) != mwrap) begin
      miscompares++;
      $display("FAIL model t=%0t got d%0d m%0d y%0d md%0d e%0d w%0d want d%0d m%0d y%0d md%0d e%0d w%0d",
               $time, bus.day_o, bus.mon_o, bus.yr_o, bus.mode_o,
               bus.eom_o, bus.yr_wrap_o, md, mm, my, mmode, eom, mwrap);
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press_set();
    bus.set_btn = 1'b1; cyc();
    bus.set_btn = 1'b0; cyc();
  endtask

  task automatic press_adv();
    bus.adv_btn = 1'b1; cyc();
    bus.adv_btn = 1'b0; cyc();
  endtask

  task automatic ticks(input int n);
    bus.day_tick = 1'b1;
    repeat (n) cyc();
    bus.day_tick = 1'b0;
  endtask

  // Walk the set sequence from RUN to a target date, back to RUN
  task automatic goto(input int y, input int m, input int d);
    int n;
    press_set();
    n = 0;
    while (my != y && n < 200) begin press_adv(); n++; end
    press_set();
    while (mm != m && n < 400) begin press_adv(); n++; end
    press_set();
    while (md != d && n < 600) begin press_adv(); n++; end
    press_set();
    chk("goto_budget", (n < 600) ? 1 : 0, 1);
  endtask

  initial begin
    bus.day_tick = 1'b0;
    bus.set_btn  = 1'b0;
    bus.adv_btn  = 1'b0;
    #12;
    chk("rst_day", int'(bus.day_o), 0);
    chk("rst_mode", int'(bus.mode_o), 0);
    chk("rst_wrap", int'(bus.yr_wrap_o), 0);
    @(posedge clk); #1 rst = 1'b0;
    cyc();

    // January: 30 back-to-back ticks, then rollover into February
    ticks(30);
    chk("jan_day30", int'(bus.day_o), 30);
    chk("jan_eom", int'(bus.eom_o), 1);
    ticks(1);
    chk("feb_day", int'(bus.day_o), 0);
    chk("feb_mon", int'(bus.mon_o), 1);

    // Leap year 0
    goto(0, 1, 27);
    chk("leap_eom27", int'(bus.eom_o), 0);
    ticks(1);
    chk("leap_day28", int'(bus.day_o), 28);
    chk("leap_eom28", int'(bus.eom_o), 1);
    ticks(1);
    chk("leap_roll_d", int'(bus.day_o), 0);
    chk("leap_roll_m", int'(bus.mon_o), 2);

    // Non-leap year 1
    goto(1, 1, 27);
    chk("nl_eom27", int'(bus.eom_o), 1);
    ticks(1);
    chk("nl_roll_d", int'(bus.day_o), 0);
    chk("nl_roll_m", int'(bus.mon_o), 2);

    // Year wrap 99/Dec/31 -> 0/Jan/1
    goto(99, 11, 30);
    ticks(1);
    chk("wrap_day", int'(bus.day_o), 0);
    chk("wrap_mon", int'(bus.mon_o), 0);
    chk("wrap_yr", int'(bus.yr_o), 0);
    chk("wrap_pulse", int'(bus.yr_wrap_o), 1);
    cyc();
    chk("wrap_pulse_end", int'(bus.yr_wrap_o), 0);

    // Clamp: Jan 31 of year 1 -> Feb clamps to 28th
    goto(1, 0, 30);
    press_set();
    press_set();
    bus.adv_btn = 1'b1; cyc();
    chk("clamp_mon", int'(bus.mon_o), 1);
    chk("clamp_day", int'(bus.day_o), 27);
    bus.adv_btn = 1'b0; cyc();

    // Ticks dropped in SET_DAY
    press_set();
    ticks(5);
    chk("iso_mode", int'(bus.mode_o), 3);
    chk("iso_day", int'(bus.day_o), 27);
    chk("iso_mon", int'(bus.mon_o), 1);

    // Asynchronous reset mid-cycle, with set held through release
    #2 rst = 1'b1;
    #1;
    chk("arst_mode", int'(bus.mode_o), 0);
    chk("arst_day", int'(bus.day_o), 0);
    chk("arst_mon", int'(bus.mon_o), 0);
    chk("arst_yr", int'(bus.yr_o), 0);
    bus.set_btn = 1'b1;
    cyc();
    rst = 1'b0;
    cyc(); cyc();
    chk("held_set_mode", int'(bus.mode_o), 0);
    bus.set_btn = 1'b0; cyc();

    // set + adv together in SET_YR: set wins
    press_set();
    bus.set_btn = 1'b1; bus.adv_btn = 1'b1; cyc();
    chk("sa_mode", int'(bus.mode_o), 2);
    chk("sa_yr", int'(bus.yr_o), 0);
    bus.set_btn = 1'b0; bus.adv_btn = 1'b0; cyc();
    press_set();
    press_set();

    // tick + set together in RUN: both take effect
    ticks(3);
    bus.day_tick = 1'b1; bus.set_btn = 1'b1; cyc();
    chk("ts_day", int'(bus.day_o), 4);
    chk("ts_mode", int'(bus.mode_o), 1);
    bus.day_tick = 1'b0; bus.set_btn = 1'b0; cyc();

    // adv held 10 cycles: one increment
    bus.adv_btn = 1'b1;
    repeat (10) cyc();
    bus.adv_btn = 1'b0; cyc();
    chk("hold_yr", int'(bus.yr_o), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
